// File: rtl/tsc.sv
// Transient-capture controller: an ADC sample ring buffer with a level trigger,
// a free-running timestamp, and a serial readout of the captured window.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ADC held in reset; waiting for start
// S_RUN      | sampling into the ring buffer; watching for trigger level
// S_TRIG     | trigger seen; collecting the remaining post-trigger samples
// S_DONE     | capture frozen; waiting for a send-buffer request
// S_SEND     | shifting 256 buffer bits out on SD, oldest byte first, MSB first
module tsc #(
  parameter logic [7:0] TRIG_LEVEL = 8'd200,
  parameter int         PRE_TRIG   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        SBF,
  input  logic        rdy,
  input  logic [7:0]  dat,
  output logic        req,
  output logic        rst,
  output logic [31:0] CD,
  output logic        TRD,
  output logic        SD
);

  // Post-trigger samples minus one; the trigger sample itself is the first.
  localparam logic [4:0] POST_M1 = 5'(31 - PRE_TRIG);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_TRIG = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;

  logic [2:0]  state;
  logic [31:0] timer;
  logic [4:0]  wptr;
  logic [7:0]  mem [32];
  logic        blank;
  logic [4:0]  post_cnt;
  logic [7:0]  send_cnt;
  logic        capturing;
  logic        accept;
  logic [4:0]  rd_idx;

  assign capturing = (state == S_RUN) || (state == S_TRIG);
  // req drops for exactly one cycle after every accepted sample.
  assign req       = capturing && !blank;
  assign accept    = req && rdy;
  assign rst       = (state == S_IDLE);

  // send_cnt counts 255 down to 0: upper bits select the byte offset from the
  // oldest slot, lower bits select the bit, which gives MSB-first naturally.
  assign rd_idx = wptr + ~send_cnt[7:3];
  assign SD     = (state == S_SEND) && mem[rd_idx][send_cnt[2:0]];

  // Free-running timestamp, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) timer <= '0;
    else       timer <= timer + 32'd1;
  end

  // Ring buffer; cleared on a new capture so unwritten slots read back as zero.
  always_ff @(posedge clk) begin
    if (reset || (state == S_IDLE && start)) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wptr] <= dat;
    end
  end

  // Sequencing FSM with trigger capture and post-trigger/send down-counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wptr     <= '0;
      blank    <= 1'b0;
      post_cnt <= '0;
      send_cnt <= '0;
      TRD      <= 1'b0;
      CD       <= '0;
    end else begin
      blank <= accept;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            wptr  <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            wptr <= wptr + 5'd1;
            if (dat >= TRIG_LEVEL) begin
              TRD      <= 1'b1;
              CD       <= timer;
              post_cnt <= POST_M1;
              state    <= (POST_M1 == 5'd0) ? S_DONE : S_TRIG;
            end
          end
        end
        S_TRIG: begin
          if (accept) begin
            wptr     <= wptr + 5'd1;
            post_cnt <= post_cnt - 5'd1;
            if (post_cnt == 5'd1) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (SBF) begin
            state    <= S_SEND;
            send_cnt <= 8'hFF;
          end
        end
        S_SEND: begin
          send_cnt <= send_cnt - 8'd1;
          if (send_cnt == 8'd0) begin
            state <= S_IDLE;
            TRD   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsc.sv
// Randomized bench for tsc: a stimulus process drives inputs and advances a
// behavioural model, pushing the expected outputs per cycle into a scoreboard;
// a monitor pops and compares on the falling edge.
module tb_tsc;

  localparam int POST = 16;
  localparam int TRIG = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, SBF = 1'b0, rdy = 1'b0;
  logic [7:0]  dat = 8'd0;
  logic        req, rst, TRD, SD;
  logic [31:0] CD;

  tsc dut (
    .clk(clk), .reset(reset), .start(start), .SBF(SBF), .rdy(rdy), .dat(dat),
    .req(req), .rst(rst), .CD(CD), .TRD(TRD), .SD(SD)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        rst;
    logic        trd;
    logic        sd;
    logic [31:0] cd;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: mode 0 idle, 1 waiting for trigger, 2 post-trigger,
  // 3 holding capture, 4 sending.
  int          m_mode = 0;
  bit          m_blank = 0;
  logic [31:0] m_timer = '0;
  logic [31:0] m_cd = '0;
  bit          m_trd = 0;
  int          post_left = 0;
  int          bit_idx = 0;
  byte unsigned caps[$];
  byte unsigned frame[32];

  // Window sent out is the last 32 accepted samples, zero-padded in front.
  task automatic build_frame();
    int n;
    n = caps.size();
    for (int i = 0; i < 32; i++) begin
      int k;
      k = n - 32 + i;
      frame[i] = (k >= 0) ? caps[k] : 8'd0;
    end
  endtask

  task automatic model_edge(input bit r, s, b, rd, input logic [7:0] d);
    logic [31:0] t_edge;
    bit acc;
    if (r) begin
      m_mode = 0; m_timer = '0; m_cd = '0; m_trd = 0; m_blank = 0;
      caps.delete();
    end else begin
      t_edge  = m_timer;
      m_timer = m_timer + 32'd1;
      case (m_mode)
        0: if (s) begin m_mode = 1; m_blank = 0; caps.delete(); end
        1, 2: begin
          acc = !m_blank && rd;
          m_blank = acc;
          if (acc) begin
            caps.push_back(d);
            if (m_mode == 1 && int'(d) >= TRIG) begin
              m_trd = 1; m_cd = t_edge; post_left = POST - 1;
              m_mode = (post_left == 0) ? 3 : 2;
            end else if (m_mode == 2) begin
              post_left--;
              if (post_left == 0) m_mode = 3;
            end
            if (m_mode == 3) build_frame();
          end
        end
        3: if (b) begin m_mode = 4; bit_idx = 0; end
        4: begin
          bit_idx++;
          if (bit_idx == 256) begin m_mode = 0; m_trd = 0; end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic step(input bit r, s, b, rd, input logic [7:0] d);
    exp_t e;
    byte unsigned fb;
    reset = r; start = s; SBF = b; rdy = rd; dat = d;
    model_edge(r, s, b, rd, d);
    @(posedge clk);
    #1;
    e.req = (m_mode == 1 || m_mode == 2) && !m_blank;
    e.rst = (m_mode == 0);
    e.trd = m_trd;
    e.cd  = m_cd;
    e.sd  = 1'b0;
    if (m_mode == 4) begin
      fb   = frame[bit_idx / 8];
      e.sd = fb[7 - (bit_idx % 8)];
    end
    sb_q.push_back(e);
  endtask

  function automatic logic [7:0] adc_val(int ntrig, int pre_lo, int pre_hi, logic [7:0] trig);
    int n;
    n = caps.size();
    if (n < ntrig) return 8'($urandom_range(pre_hi, pre_lo));
    if (n == ntrig) return trig;
    return 8'($urandom);
  endfunction

  // Start a capture and feed samples until the model reports it complete.
  task automatic capture(input int ntrig, input int pre_lo, input int pre_hi, input logic [7:0] trig);
    int c;
    step(0, 1, 0, 0, 8'd0);
    c = 0;
    while (m_mode != 3 && c < 600) begin
      step(0, 1'($urandom % 2), 0, ($urandom % 4) != 0, adc_val(ntrig, pre_lo, pre_hi, trig));
      c++;
    end
    if (m_mode != 3) begin
      miscompares++;
      $display("FAIL capture_timeout: model mode %0d after %0d cycles, want capture complete", m_mode, c);
    end
  endtask

  task automatic send_all();
    step(0, 0, 1, 0, 8'd0);
    repeat (256) step(0, 0, 1'($urandom % 2), 1'($urandom % 2), 8'($urandom));
  endtask

  // Monitor: compare DUT outputs with the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    bit bad;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      bad = 0;
      if (req !== e.req) begin bad = 1; $display("FAIL req: got %b want %b at %0t", req, e.req, $time); end
      if (rst !== e.rst) begin bad = 1; $display("FAIL rst: got %b want %b at %0t", rst, e.rst, $time); end
      if (TRD !== e.trd) begin bad = 1; $display("FAIL TRD: got %b want %b at %0t", TRD, e.trd, $time); end
      if (CD !== e.cd)   begin bad = 1; $display("FAIL CD: got %0d want %0d at %0t", CD, e.cd, $time); end
      if (SD !== e.sd)   begin bad = 1; $display("FAIL SD: got %b want %b at %0t", SD, e.sd, $time); end
      if (bad) miscompares++;
    end
  end

  initial begin
    // Reset, then idle with stray rdy/SBF.
    step(1, 0, 0, 0, 8'd0);
    step(1, 1, 1, 1, 8'd0);
    repeat (5) step(0, 0, 1'($urandom % 2), 1'($urandom % 2), 8'($urandom));

    // Ramp below threshold: req toggling, no trigger, stray start/SBF ignored.
    step(0, 1, 0, 0, 8'd0);
    repeat (80) step(0, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 8'(caps.size()));
    step(1, 0, 0, 0, 8'd0);

    // 20 samples of 10, trigger 250, then post-trigger data; hold in DONE; send.
    capture(20, 10, 10, 8'd250);
    repeat (3) step(0, 1, 0, 1, 8'd255);
    send_all();
    repeat (3) step(0, 0, 1, 1, 8'd250);

    // Trigger at the 3rd sample: the window leads with 14 zero bytes.
    // Start and SBF together in DONE.
    capture(2, 0, 199, 8'd255);
    step(0, 1, 1, 0, 8'd0);
    repeat (256) step(0, 0, 0, 1'($urandom % 2), 8'($urandom));
    step(0, 0, 0, 0, 8'd0);

    // Threshold boundary (199 pre, 200 trigger), reset mid-send, recapture.
    capture(5, 199, 199, 8'd200);
    step(0, 0, 1, 0, 8'd0);
    repeat (100) step(0, 0, 0, 0, 8'd0);
    step(1, 1, 1, 1, 8'd250);
    step(0, 0, 0, 0, 8'd0);
    capture(8, 0, 199, 8'd230);
    send_all();
    repeat (3) step(0, 0, 0, 0, 8'd0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
